// File: rtl/led_fade_pkg.sv
// Shared types and defaults for the LED fade driver.
// Holds the fade state enum, default parameters and the prescaler width helper.
package led_fade_pkg;

  typedef enum logic [1:0] {
    OFF,
    RAMP_UP,
    ON,
    RAMP_DOWN
  } led_fade_state_t;

  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_STEP_DIV = 1024;

  // A divide-by-one prescaler still needs a 1-bit register to stay legal.
  function automatic int presc_width(input int step_div);
    return (step_div <= 2) ? 1 : $clog2(step_div);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with duty compare and registered, optionally
// inverted, LED drive.
module led_pwm_gen #(
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_led_pin
);

  localparam logic L_INACTIVE = (ACTIVE_LOW != 0);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_led_pin;
  logic                w_lit;

  // Full duty forces the LED on so the top step is a solid light, not 255/256.
  assign w_lit = (i_duty == '1) || (r_pwm_cnt < i_duty);

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_led_pin <= L_INACTIVE;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led_pin <= w_lit ^ L_INACTIVE;
    end
  end

  assign o_led_pin = r_led_pin;

endmodule

// File: rtl/led_fade_driver.sv
// PIO LED level to faded PWM LED pin: linear ramps between off and full on.
// Optional LED_FADE_DRIVER_SYNC_EN adds a two-flop synchronizer on led_req.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int STEP_DIV   = DEF_STEP_DIV,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                led_req,
  output logic                led_pin,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int                  PW         = presc_width(STEP_DIV);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

  led_fade_state_t     r_state;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_busy;
  logic [PW-1:0]       r_presc;
  logic                w_req_s;
  logic                w_step;

`ifdef LED_FADE_DRIVER_SYNC_EN
  logic r_req_meta;
  logic r_req_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_meta <= 1'b0;
      r_req_sync <= 1'b0;
    end else begin
      r_req_meta <= led_req;
      r_req_sync <= r_req_meta;
    end
  end

  assign w_req_s = r_req_sync;
`else
  assign w_req_s = led_req;
`endif

  assign w_step = (r_presc == PRESC_LAST);

  // A request change wins over a coincident step: the state flips, duty holds.
  // NOTE: only control/datapath flops exist here, so all of them take the
  // asynchronous reset; there is no memory array to leave unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= OFF;
      r_duty  <= '0;
      r_busy  <= 1'b0;
      r_presc <= '0;
    end else begin
      case (r_state)
        OFF: begin
          r_presc <= '0;
          if (w_req_s) begin
            r_state <= RAMP_UP;
            r_busy  <= 1'b1;
          end
        end
        ON: begin
          r_presc <= '0;
          if (!w_req_s) begin
            r_state <= RAMP_DOWN;
            r_busy  <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (!w_req_s) begin
            r_state <= RAMP_DOWN;
            r_presc <= '0;
          end else if (w_step) begin
            r_presc <= '0;
            if (r_duty >= DUTY_MAX - DUTY_ONE) begin
              r_duty  <= DUTY_MAX;
              r_state <= ON;
              r_busy  <= 1'b0;
            end else begin
              r_duty <= r_duty + DUTY_ONE;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        RAMP_DOWN: begin
          if (w_req_s) begin
            r_state <= RAMP_UP;
            r_presc <= '0;
          end else if (w_step) begin
            r_presc <= '0;
            if (r_duty <= DUTY_ONE) begin
              r_duty  <= '0;
              r_state <= OFF;
              r_busy  <= 1'b0;
            end else begin
              r_duty <= r_duty - DUTY_ONE;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        default: begin
          r_state <= OFF;
          r_duty  <= '0;
          r_busy  <= 1'b0;
          r_presc <= '0;
        end
      endcase
    end
  end

  led_pwm_gen #(
    .PWM_BITS  (PWM_BITS),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_pwm (
    .clk      (clk),
    .reset    (reset),
    .i_duty   (r_duty),
    .o_led_pin(led_pin)
  );

  assign duty = r_duty;
  assign busy = r_busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver (PWM_BITS=4, STEP_DIV=4) with a
// behavioural fade model; honours LED_FADE_DRIVER_SYNC_EN when defined.
module tb_led_fade_driver;

  localparam int PWM_BITS = 4;
  localparam int STEP_DIV = 4;
  localparam int MAXD     = (1 << PWM_BITS) - 1;
  localparam int PERIOD   = 1 << PWM_BITS;
`ifdef LED_FADE_DRIVER_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                led_req = 1'b0;
  logic                led_pin, led_pin_al;
  logic [PWM_BITS-1:0] duty, duty_al;
  logic                busy, busy_al;

  int n_checks = 0;
  int n_errors = 0;

  // Model: brightness level, direction of travel and time spent since the
  // last step or reversal; the LED pin follows the previous cycle's compare.
  int m_duty, m_phase, m_cnt;
  bit m_moving, m_up, m_pin, m_s1, m_s2;

  always #5 clk = ~clk;

  led_fade_driver #(.PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .led_req(led_req),
    .led_pin(led_pin), .duty(duty), .busy(busy)
  );

  led_fade_driver #(.PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset), .led_req(led_req),
    .led_pin(led_pin_al), .duty(duty_al), .busy(busy_al)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_duty = 0; m_phase = 0; m_cnt = 0;
    m_moving = 0; m_up = 0; m_pin = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_step();
    bit req_s;
    if (SYNC != 0) begin
      req_s = m_s2; m_s2 = m_s1; m_s1 = led_req;
    end else begin
      req_s = led_req;
    end
    m_pin = (m_duty == MAXD) || (m_cnt < m_duty);
    m_cnt = (m_cnt + 1) % PERIOD;
    if (!m_moving) begin
      if (m_duty == 0 && req_s) begin
        m_moving = 1; m_up = 1; m_phase = 0;
      end else if (m_duty == MAXD && !req_s) begin
        m_moving = 1; m_up = 0; m_phase = 0;
      end
    end else if (req_s != m_up) begin
      m_up = req_s; m_phase = 0;
    end else if (m_phase == STEP_DIV - 1) begin
      m_phase = 0;
      if (m_up) m_duty = (m_duty < MAXD) ? m_duty + 1 : MAXD;
      else      m_duty = (m_duty > 0) ? m_duty - 1 : 0;
      if ((m_up && m_duty == MAXD) || (!m_up && m_duty == 0)) m_moving = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic compare_all();
    check("duty", 32'(duty), 32'(m_duty));
    check("busy", 32'(busy), 32'(m_moving));
    check("led_pin", 32'(led_pin), 32'(m_pin));
    check("duty_al", 32'(duty_al), 32'(m_duty));
    check("led_pin_al", 32'(led_pin_al), 32'(!m_pin));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_duty", 32'(duty), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pin", 32'(led_pin), 32'd0);
    check("reset_pin_al", 32'(led_pin_al), 32'd1);
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_duty(input string tag, input int target);
    int n = 0;
    while (int'(duty) != target && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(duty), 32'(target));
  endtask

  initial begin
    int n, highs, lows;
    bit seen;
    model_reset();

    // Reset held for three cycles.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_pin_al", 32'(led_pin_al), 32'd1);
    reset = 1'b0;

    // Fade in: request latency, then full 0->15 ramp in 60 cycles.
    led_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!busy && n < 10);
    check("req_latency", 32'(n), 32'(1 + 2 * SYNC));
    n = 0;
    while (int'(duty) != MAXD && n < 200) begin
      tick();
      n++;
    end
    check("full_ramp_cycles", 32'(n), 32'(STEP_DIV * MAXD));
    check("on_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    highs = 0; lows = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      highs += int'(led_pin);
      lows  += int'(!led_pin_al);
    end
    check("on_highs", 32'(highs), 32'(PERIOD));
    check("on_lows_al", 32'(lows), 32'(PERIOD));

    // Fade out fully, ramp back to 7, then reverse.
    led_req = 1'b0;
    wait_duty("fade_out_zero", 0);
    tick();
    led_req = 1'b1;
    wait_duty("reach_7", 7);
    led_req = 1'b0;
    for (int i = 0; i < 4 + 2 * SYNC; i++) tick();
    check("reverse_hold", 32'(duty), 32'd7);
    tick();
    check("reverse_step", 32'(duty), 32'd6);
    wait_duty("reverse_to_zero", 0);
    for (int i = 0; i < 4; i++) tick();
    check("off_busy", 32'(busy), 32'd0);
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      highs += int'(led_pin);
    end
    check("off_highs", 32'(highs), 32'd0);

    // Freeze at duty 5 by toggling the request every cycle.
    led_req = 1'b1;
    wait_duty("reach_5", 5);
    for (int i = 0; i < 8; i++) begin
      led_req = ~led_req;
      tick();
    end
    highs = 0; lows = 0;
    for (int i = 0; i < PERIOD; i++) begin
      led_req = ~led_req;
      tick();
      highs += int'(led_pin);
      lows  += int'(!led_pin_al);
    end
    check("pwm5_highs", 32'(highs), 32'd5);
    check("pwm5_lows_al", 32'(lows), 32'd5);
    check("pwm5_duty", 32'(duty), 32'd5);

    // Reset mid-ramp at duty 9, then ramp restarts from 0.
    led_req = 1'b1;
    wait_duty("reach_9", 9);
    pulse_reset();
    n = 0;
    while (int'(duty) == 0 && n < 40) begin
      tick();
      n++;
    end
    check("restart_first_step", 32'(duty), 32'd1);

    // One-cycle request glitch from OFF is still honoured.
    led_req = 1'b0;
    pulse_reset();
    tick();
    led_req = 1'b1;
    tick();
    led_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) seen = 1;
      tick();
    end
    check("glitch_honoured", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) tick();

    // Randomised request levels and hold times with occasional resets.
    for (int r = 0; r < 40; r++) begin
      led_req = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 70));
      for (int i = 0; i < n; i++) tick();
      if ($urandom_range(0, 9) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
